// File: rtl/usb_txn_arbiter_pkg.sv
// Shared types and helpers for the USB host transaction arbiter.
// Holds the FSM state encoding, the latched transaction record and round-robin index math.
package usb_txn_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] mempage;
    logic [63:0] wdata;
  } txn_t;

  // Index 'off' positions after 'base' on a ring of n requesters.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/usb_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// The pointer register is owned by the instantiating module.
module rr_arbiter
  import usb_txn_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Scan from the farthest slot back to ptr so the nearest valid request wins.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IW'(rr_index(int'(ptr), i, N))]) begin
        grant                                   = '0;
        grant[IW'(rr_index(int'(ptr), i, N))]   = 1'b1;
        grant_idx                               = IW'(rr_index(int'(ptr), i, N));
      end
    end
  end

endmodule

// File: rtl/usb_txn_arbiter.sv
// Round-robin arbiter sharing one RW_FSM between NUM_REQ requesters, one transaction in flight.
// Optional retry-on-failure is enabled by defining USB_ARB_RETRY_EN.
module usb_txn_arbiter
  import usb_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*16-1:0] req_mempage,
  input  logic [NUM_REQ*64-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_success,
  output logic [63:0]           rsp_rdata,
  output logic                  read_start,
  output logic                  write_start,
  output logic [15:0]           read_mempage,
  output logic [15:0]           write_mempage,
  output logic [63:0]           write_data,
  input  logic                  finished,
  input  logic                  read_success,
  input  logic                  write_success,
  input  logic [63:0]           read_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef USB_ARB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  arb_state_t         state_q, state_d;
  txn_t               txn_q, txn_sel;
  logic [NUM_REQ-1:0] grant, gnt_q;
  logic [PTR_W-1:0]   grant_idx, ptr_q;
  logic [TMR_W-1:0]   timer_q;
  logic [RTY_W-1:0]   retry_q;
  logic               succ_q;
  logic [63:0]        rdata_q;
  logic               accept, issue_go, in_wait, in_resp;
  logic               timeout, wait_succ, wait_fail, retry;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    txn_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        txn_sel.write   = req_write[i];
        txn_sel.mempage = req_mempage[i*16 +: 16];
        txn_sel.wdata   = req_wdata[i*64 +: 64];
      end
    end
  end

  // A start is withheld while finished is still high from the previous transaction,
  // so WAIT only ever sees a finished that belongs to the current start.
  assign accept    = (state_q == ARB_IDLE) && (|req_valid);
  assign issue_go  = (state_q == ARB_ISSUE) && !finished;
  assign in_wait   = (state_q == ARB_WAIT);
  assign in_resp   = (state_q == ARB_RESP);
  assign wait_succ = txn_q.write ? write_success : read_success;
  assign timeout   = in_wait && !finished && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign wait_fail = in_wait && ((finished && !wait_succ) || timeout);
  assign retry     = RETRY_EN && wait_fail && (retry_q < RTY_W'(MAX_RETRY));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
      ARB_ISSUE: if (!finished) state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (retry)                     state_d = ARB_ISSUE;
        else if (finished || timeout)  state_d = ARB_RESP;
      end
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      txn_q   <= '0;
      timer_q <= '0;
      retry_q <= '0;
      succ_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (accept) begin
        txn_q   <= txn_sel;
        gnt_q   <= grant;
        ptr_q   <= PTR_W'(rr_index(int'(grant_idx), 1, NUM_REQ));
        retry_q <= '0;
      end
      if (issue_go) timer_q <= '0;
      if (in_wait) begin
        timer_q <= timer_q + 1'b1;
        if (finished) begin
          succ_q  <= wait_succ;
          rdata_q <= txn_q.write ? 64'd0 : read_data;
        end else if (timeout) begin
          succ_q  <= 1'b0;
          rdata_q <= '0;
        end
      end
      if (retry) retry_q <= retry_q + 1'b1;
    end
  end

  // req_ready is forced low while reset is asserted so every output reads 0 in reset.
  assign req_ready     = (state_q == ARB_IDLE && reset_n) ? grant : '0;
  assign read_start    = issue_go && !txn_q.write;
  assign write_start   = issue_go && txn_q.write;
  assign read_mempage  = txn_q.write ? 16'd0 : txn_q.mempage;
  assign write_mempage = txn_q.write ? txn_q.mempage : 16'd0;
  assign write_data    = txn_q.write ? txn_q.wdata : 64'd0;
  assign rsp_valid     = in_resp ? gnt_q : '0;
  assign rsp_success   = in_resp && succ_q;
  assign rsp_rdata     = in_resp ? rdata_q : 64'd0;

endmodule

// File: tb/tb_usb_txn_arbiter.sv
// Directed self-checking bench for usb_txn_arbiter (2 requesters, default timeout).
// Covers reset, read/write paths, round-robin order, timeout, reset abort, handshake and retry.
module tb_usb_txn_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int TIMEOUT_CYC = 4096;
  localparam int MAX_RETRY   = 3;
`ifdef USB_ARB_RETRY_EN
  localparam int EXP_FAIL_PULSES = 4;
  localparam int EXP_OK2_PULSES  = 2;
  localparam bit EXP_OK2_SUCC    = 1'b1;
`else
  localparam int EXP_FAIL_PULSES = 1;
  localparam int EXP_OK2_PULSES  = 1;
  localparam bit EXP_OK2_SUCC    = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_REQ*16-1:0] req_mempage;
  logic [NUM_REQ*64-1:0] req_wdata;
  logic                  rsp_success, read_start, write_start;
  logic [63:0]           rsp_rdata, write_data, read_data;
  logic [15:0]           read_mempage, write_mempage;
  logic                  finished, read_success, write_success;

  int n_vec  = 0;
  int n_miss = 0;

  usb_txn_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mempage(req_mempage), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_success(rsp_success), .rsp_rdata(rsp_rdata),
    .read_start(read_start), .write_start(write_start),
    .read_mempage(read_mempage), .write_mempage(write_mempage), .write_data(write_data),
    .finished(finished), .read_success(read_success), .write_success(write_success),
    .read_data(read_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write from req0; finished pulses one cycle after each start, success only on try ok_on.
  task automatic run_retry(input int ok_on, output int pulses, output logic [1:0] rv,
                           output logic succ);
    bit pend;
    bit got;
    pulses = 0; pend = 0; got = 0; rv = '0; succ = 1'b0;
    req_valid = 2'b01; req_write = 2'b01; settle();
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 200 && !got; c++) begin
      finished      = pend;
      write_success = pend && (pulses == ok_on);
      settle();
      if (rsp_valid != 0) begin
        got = 1; rv = rsp_valid; succ = rsp_success;
      end else if (write_start) begin
        pulses++; pend = 1;
      end else begin
        pend = 0;
      end
      if (!got) tick();
    end
    finished = 1'b0; write_success = 1'b0;
    tick(); settle();
  endtask

  int          cnt;
  bit          got;
  int          pulses;
  logic [1:0]  rv;
  logic        succ;

  initial begin
    reset_n = 1'b0; req_valid = '0; req_write = '0; req_mempage = '0; req_wdata = '0;
    finished = 1'b0; read_success = 1'b0; write_success = 1'b0; read_data = '0;
    repeat (3) tick();
    settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_success", rsp_success, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_starts", {read_start, write_start}, 0);
    chk("rst_pages", {read_mempage, write_mempage}, 0);
    chk("rst_write_data", write_data, 0);

    // Basic read from req0, finished at WAIT+5
    reset_n = 1'b1; tick();
    req_valid = 2'b01; req_write = 2'b00; req_mempage = 32'h0000_0010; settle();
    chk("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; settle();
    chk("t1_read_start", read_start, 1);
    chk("t1_write_start", write_start, 0);
    chk("t1_read_page", read_mempage, 16'h0010);
    chk("t1_ready_issue", req_ready, 0);
    tick(); settle();
    chk("t1_start_one_shot", read_start, 0);
    repeat (4) tick();
    tick();
    finished = 1'b1; read_success = 1'b1; read_data = 64'hDEAD_BEEF_0123_4567; settle();
    chk("t1_no_early_rsp", rsp_valid, 0);
    tick(); finished = 1'b0; read_success = 1'b0; read_data = '0; settle();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_success", rsp_success, 1);
    chk("t1_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    tick(); settle();
    chk("t1_rsp_one_shot", rsp_valid, 0);

    // Both requesters hold valid from reset: writes alternate 0,1,0,1
    reset_n = 1'b0; req_valid = 2'b11; req_write = 2'b11;
    req_mempage = {16'h2222, 16'h1111};
    req_wdata = {64'hBBBB_0000_2222_0002, 64'hAAAA_0000_1111_0001};
    settle();
    chk("t2_ready_in_reset", req_ready, 0);
    tick(); reset_n = 1'b1; settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_ready_%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick(); settle();
      chk($sformatf("t2_write_start_%0d", k), write_start, 1);
      chk($sformatf("t2_page_%0d", k), write_mempage, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      chk($sformatf("t2_data_%0d", k), write_data,
          (k % 2 == 0) ? 64'hAAAA_0000_1111_0001 : 64'hBBBB_0000_2222_0002);
      tick(); finished = 1'b1; write_success = 1'b1; settle();
      tick(); finished = 1'b0; write_success = 1'b0; settle();
      chk($sformatf("t2_rsp_valid_%0d", k), rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_rsp_success_%0d", k), rsp_success, 1);
      chk($sformatf("t2_rsp_rdata_%0d", k), rsp_rdata, 0);
      tick(); settle();
    end
    req_valid = 2'b00;

    // Write from req1 with finished never asserted: timeout
    req_valid = 2'b10; req_write = 2'b10; req_mempage = {16'hABCD, 16'h0000}; settle();
    chk("t3_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00; settle();
    chk("t3_write_start", write_start, 1);
    cnt = 0; got = 0;
    while (!got && cnt < TIMEOUT_CYC + 10) begin
      tick(); settle(); cnt++;
      if (cnt == TIMEOUT_CYC / 2) chk("t3_page_stable", write_mempage, 16'hABCD);
      if (rsp_valid != 0) got = 1;
    end
    chk("t3_rsp_latency", cnt, TIMEOUT_CYC + 1);
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_rsp_success", rsp_success, 0);
    chk("t3_rsp_rdata", rsp_rdata, 0);
    tick(); settle();

    // finished and timeout in the same cycle: finished wins
    req_valid = 2'b01; req_write = 2'b01; req_mempage = {16'h0000, 16'h4444}; settle();
    tick(); req_valid = 2'b00; settle();
    chk("t4_write_start", write_start, 1);
    repeat (TIMEOUT_CYC - 1) tick();
    chk("t4_no_early_rsp", rsp_valid, 0);
    tick(); finished = 1'b1; write_success = 1'b1; settle();
    tick(); finished = 1'b0; write_success = 1'b0; settle();
    chk("t4_rsp_valid", rsp_valid, 2'b01);
    chk("t4_rsp_success", rsp_success, 1);
    tick(); settle();

    // Stale finished level holds the start off until it drops
    req_valid = 2'b01; req_write = 2'b00; req_mempage = {16'h0000, 16'h0707};
    finished = 1'b1; settle();
    tick(); req_valid = 2'b00; settle();
    chk("t7_start_held_a", read_start, 0);
    tick(); settle();
    chk("t7_start_held_b", read_start, 0);
    finished = 1'b0; settle();
    chk("t7_start_released", read_start, 1);
    chk("t7_read_page", read_mempage, 16'h0707);
    tick(); finished = 1'b1; read_success = 1'b1; read_data = 64'h0000_0000_0000_1234; settle();
    tick(); finished = 1'b0; read_success = 1'b0; read_data = '0; settle();
    chk("t7_rsp_valid", rsp_valid, 2'b01);
    chk("t7_rsp_rdata", rsp_rdata, 64'h0000_0000_0000_1234);
    tick(); settle();

    // Reset during WAIT aborts without a response
    req_valid = 2'b01; req_write = 2'b00; req_mempage = {16'h0000, 16'h0055}; settle();
    tick(); req_valid = 2'b00; settle();
    chk("t5_read_start", read_start, 1);
    tick(); tick();
    chk("t5_page_before_rst", read_mempage, 16'h0055);
    reset_n = 1'b0; settle();
    chk("t5_rst_page", read_mempage, 0);
    chk("t5_rst_starts", {read_start, write_start}, 0);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    tick(); reset_n = 1'b1;
    req_valid = 2'b10; req_write = 2'b00; req_mempage = {16'h0077, 16'h0000}; settle();
    chk("t5_ready_after", req_ready, 2'b10);
    tick(); req_valid = 2'b00; settle();
    chk("t5_read_start_after", read_start, 1);
    chk("t5_page_after", read_mempage, 16'h0077);
    tick(); finished = 1'b1; read_success = 1'b1; read_data = 64'h0000_0000_0000_CAFE; settle();
    tick(); finished = 1'b0; read_success = 1'b0; read_data = '0; settle();
    chk("t5_rsp_valid", rsp_valid, 2'b10);
    chk("t5_rsp_rdata", rsp_rdata, 64'h0000_0000_0000_CAFE);
    tick(); settle();

    // Failure handling: always failing, then succeeding on the second attempt
    req_mempage = {16'h0000, 16'h0099};
    run_retry(0, pulses, rv, succ);
    chk("t6_fail_pulses", pulses, EXP_FAIL_PULSES);
    chk("t6_fail_rsp_valid", rv, 2'b01);
    chk("t6_fail_success", succ, 0);
    run_retry(2, pulses, rv, succ);
    chk("t6_ok2_pulses", pulses, EXP_OK2_PULSES);
    chk("t6_ok2_rsp_valid", rv, 2'b01);
    chk("t6_ok2_success", succ, EXP_OK2_SUCC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
